// File: rtl/systolic_pkg.sv
// Shared types and elaboration helpers for the systolic tile engine.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  typedef enum logic {
    MODE_UNSIGNED = 1'b0,
    MODE_SIGNED   = 1'b1
  } signed_mode_t;

  // Cycles needed for the last operand pair to reach PE(N-1,N-1).
  function automatic int mult_cycles(input int n);
    return 3 * n - 2;
  endfunction

  function automatic int cnt_width(input int n);
    return $clog2(3 * n - 1);
  endfunction

endpackage

// File: rtl/systolic_mac_pe.sv
// One processing element: forwards A right and B down, accumulates a*b.
module systolic_mac_pe
  import systolic_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              clear,
  input  logic              enable,
  input  signed_mode_t      mode,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [ACC_W-1:0]  acc
);

  localparam int PROD_W = 2 * DATA_W;

  logic [PROD_W-1:0] a_ext;
  logic [PROD_W-1:0] b_ext;
  logic [PROD_W-1:0] prod;
  logic [ACC_W-1:0]  prod_ext;

  // Low 2*DATA_W bits of the extended product are exact in both modes.
  assign a_ext    = (mode == MODE_SIGNED) ? {{DATA_W{a_in[DATA_W-1]}}, a_in}
                                          : {{DATA_W{1'b0}}, a_in};
  assign b_ext    = (mode == MODE_SIGNED) ? {{DATA_W{b_in[DATA_W-1]}}, b_in}
                                          : {{DATA_W{1'b0}}, b_in};
  assign prod     = a_ext * b_ext;
  assign prod_ext = (mode == MODE_SIGNED) ? {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod}
                                          : {{(ACC_W-PROD_W){1'b0}}, prod};

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values,
      // which is what makes the neighbouring PEs form a true pipeline.
      if (enable) begin
        a_out <= a_in;
        b_out <= b_in;
      end
      if (clear)       acc <= '0;
      else if (enable) acc <= acc + prod_ext;
    end
  end

endmodule

// File: rtl/systolic_tile_engine.sv
// N x N output-stationary systolic matmul with handshakes, signed mode and accumulate.
module systolic_tile_engine
  import systolic_pkg::*;
#(
  parameter int N      = 16,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic                           i_clk,
  input  logic                           i_arst,
  input  logic [N-1:0][N-1:0][DATA_W-1:0] i_a,
  input  logic [N-1:0][N-1:0][DATA_W-1:0] i_b,
  input  logic                           i_valid,
  output logic                           o_ready,
  input  logic                           i_accumulate,
  input  logic                           i_signed,
  output logic [N-1:0][N-1:0][ACC_W-1:0]  o_c,
  output logic                           o_valid,
  input  logic                           i_ready
);

  localparam int MULT_CYCLES = mult_cycles(N);
  localparam int CNT_W       = cnt_width(N);
  localparam int SKEW_LEN    = 2 * N - 1;

  if ((N < 3) || (N > 256)) begin : g_bad_n
    $error("systolic_tile_engine: N=%0d outside 3..256", N);
  end
  if ((DATA_W < 2) || (DATA_W > 16)) begin : g_bad_data_w
    $error("systolic_tile_engine: DATA_W=%0d outside 2..16", DATA_W);
  end
  if (ACC_W < 2 * DATA_W + $clog2(N)) begin : g_bad_acc_w
    $error("systolic_tile_engine: ACC_W=%0d too narrow", ACC_W);
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  signed_mode_t     mode_q;
  logic             accept;
  logic             computing;
  logic             clear_acc;

  logic [DATA_W-1:0] skew_a [N][SKEW_LEN];
  logic [DATA_W-1:0] skew_b [N][SKEW_LEN];
  logic [DATA_W-1:0] a_link [N][N+1];
  logic [DATA_W-1:0] b_link [N+1][N];

  assign accept    = o_ready && i_valid;
  assign computing = (state_q == COMPUTE);
  assign clear_acc = accept && !i_accumulate;

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d = state_q;
    o_ready = 1'b0;
    o_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_d = COMPUTE;
      end
      COMPUTE: begin
        if (cnt_q == CNT_W'(MULT_CYCLES)) state_d = DONE;
      end
      DONE: begin
        o_valid = 1'b1;
        if (i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Row r of A starts r slots late and column c of B starts c slots late,
  // so matching k-indices meet in PE(r,c) on the same cycle.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      cnt_q  <= '0;
      mode_q <= MODE_UNSIGNED;
      // NOTE: the skew arrays are flops, not RAM, so they take the async reset like any register.
      for (int r = 0; r < N; r++) begin
        for (int s = 0; s < SKEW_LEN; s++) begin
          skew_a[r][s] <= '0;
          skew_b[r][s] <= '0;
        end
      end
    end else if (accept) begin
      cnt_q  <= CNT_W'(1);
      mode_q <= signed_mode_t'(i_signed);
      for (int r = 0; r < N; r++) begin
        for (int s = 0; s < SKEW_LEN; s++) begin
          skew_a[r][s] <= '0;
          skew_b[r][s] <= '0;
        end
        for (int k = 0; k < N; k++) begin
          skew_a[r][r+k] <= i_a[r][k];
          skew_b[r][r+k] <= i_b[k][r];
        end
      end
    end else if (computing) begin
      cnt_q <= cnt_q + CNT_W'(1);
      for (int r = 0; r < N; r++) begin
        for (int s = 0; s < SKEW_LEN - 1; s++) begin
          skew_a[r][s] <= skew_a[r][s+1];
          skew_b[r][s] <= skew_b[r][s+1];
        end
        skew_a[r][SKEW_LEN-1] <= '0;
        skew_b[r][SKEW_LEN-1] <= '0;
      end
    end
  end

  for (genvar r = 0; r < N; r++) begin : g_row
    assign a_link[r][0] = skew_a[r][0];
    assign b_link[0][r] = skew_b[r][0];
    for (genvar c = 0; c < N; c++) begin : g_col
      systolic_mac_pe #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
      ) u_pe (
        .clk    (i_clk),
        .arst   (i_arst),
        .clear  (clear_acc),
        .enable (computing),
        .mode   (mode_q),
        .a_in   (a_link[r][c]),
        .b_in   (b_link[r][c]),
        .a_out  (a_link[r][c+1]),
        .b_out  (b_link[r+1][c]),
        .acc    (o_c[r][c])
      );
    end
  end

endmodule

// File: tb/tb_systolic_tile_engine.sv
// Directed bench for systolic_tile_engine: N=4/DATA_W=8 and N=3/DATA_W=4 instances.
module tb_systolic_tile_engine;

  localparam int N4  = 4;
  localparam int DW4 = 8;
  localparam int N3  = 3;
  localparam int DW3 = 4;
  localparam int AW  = 32;

  typedef logic [N4-1:0][N4-1:0][DW4-1:0] m4_t;
  typedef logic [N4-1:0][N4-1:0][AW-1:0]  c4_t;
  typedef logic [N3-1:0][N3-1:0][DW3-1:0] m3_t;
  typedef logic [N3-1:0][N3-1:0][AW-1:0]  c3_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst4, valid4, acc4, sgn4, ready4, rdy4, ov4;
  m4_t  a4, b4;
  c4_t  c4;
  logic rst3, valid3, acc3, sgn3, ready3, rdy3, ov3;
  m3_t  a3, b3;
  c3_t  c3;

  int total = 0;
  int bad   = 0;

  systolic_tile_engine #(.N(N4), .DATA_W(DW4), .ACC_W(AW)) dut4 (
    .i_clk(clk), .i_arst(rst4), .i_a(a4), .i_b(b4), .i_valid(valid4), .o_ready(rdy4),
    .i_accumulate(acc4), .i_signed(sgn4), .o_c(c4), .o_valid(ov4), .i_ready(ready4)
  );

  systolic_tile_engine #(.N(N3), .DATA_W(DW3), .ACC_W(AW)) dut3 (
    .i_clk(clk), .i_arst(rst3), .i_a(a3), .i_b(b3), .i_valid(valid3), .o_ready(rdy3),
    .i_accumulate(acc3), .i_signed(sgn3), .o_c(c3), .o_valid(ov3), .i_ready(ready3)
  );

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept a tile on dut4 and step to cycle T+11, where the result must be valid.
  task automatic run4(input string tag);
    valid4 = 1'b1;
    tick();
    valid4 = 1'b0;
    repeat (10) tick();
    check({tag, " valid"}, {rdy4, ov4}, 2'b01);
  endtask

  task automatic consume4(input string tag);
    ready4 = 1'b1;
    tick();
    ready4 = 1'b0;
    check({tag, " idle after consume"}, {rdy4, ov4}, 2'b10);
  endtask

  function automatic c3_t model3(input m3_t a, input m3_t b, input logic sgn);
    c3_t    c;
    longint s, x, y;
    for (int i = 0; i < N3; i++) begin
      for (int j = 0; j < N3; j++) begin
        s = 0;
        for (int k = 0; k < N3; k++) begin
          x = sgn ? longint'($signed(a[i][k])) : longint'(a[i][k]);
          y = sgn ? longint'($signed(b[k][j])) : longint'(b[k][j]);
          s += x * y;
        end
        c[i][j] = s[AW-1:0];
      end
    end
    return c;
  endfunction

  initial begin
    c4_t e4;
    c3_t e3;
    int  seen;

    rst4 = 1'b1; valid4 = 1'b0; acc4 = 1'b0; sgn4 = 1'b0; ready4 = 1'b0; a4 = '0; b4 = '0;
    rst3 = 1'b1; valid3 = 1'b0; acc3 = 1'b0; sgn3 = 1'b0; ready3 = 1'b0; a3 = '0; b3 = '0;
    tick();
    tick();
    check("reset handshake", {rdy4, ov4}, 2'b10);
    check("reset o_c", c4, '0);
    rst4 = 1'b0;
    rst3 = 1'b0;
    tick();

    // Identity times pattern: latency and busy window.
    a4 = '0;
    for (int i = 0; i < N4; i++) a4[i][i] = 8'd1;
    for (int i = 0; i < N4; i++)
      for (int j = 0; j < N4; j++) b4[i][j] = DW4'(4 * i + j);
    valid4 = 1'b1;
    tick();
    valid4 = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      check($sformatf("ident busy T+%0d", c), {rdy4, ov4}, 2'b00);
      tick();
    end
    check("ident valid T+11", {rdy4, ov4}, 2'b01);
    for (int i = 0; i < N4; i++)
      for (int j = 0; j < N4; j++) e4[i][j] = AW'(4 * i + j);
    check("ident c==B", c4, e4);
    consume4("ident");

    // Signed: -1 * 127 summed over 4.
    a4 = {16{8'hFF}};
    b4 = {16{8'd127}};
    sgn4 = 1'b1;
    run4("signed");
    e4 = {16{32'hFFFF_FE04}};
    check("signed c==-508", c4, e4);
    consume4("signed");

    // Accumulate across two tiles of ones.
    a4 = {16{8'd1}};
    b4 = {16{8'd1}};
    sgn4 = 1'b0;
    acc4 = 1'b0;
    run4("acc first");
    check("acc first c==4", c4, {16{32'd4}});
    consume4("acc first");
    acc4 = 1'b1;
    run4("acc second");
    check("acc second c==8", c4, {16{32'd8}});
    consume4("acc second");

    // Backpressure with an ignored i_valid pulse.
    acc4 = 1'b0;
    a4 = {16{8'd2}};
    for (int i = 0; i < N4; i++)
      for (int j = 0; j < N4; j++) b4[i][j] = DW4'(4 * i + j);
    run4("bp");
    for (int i = 0; i < N4; i++)
      for (int j = 0; j < N4; j++) e4[i][j] = AW'(48 + 8 * j);
    for (int c = 0; c < 20; c++) begin
      if (c == 5) begin
        a4 = {16{8'd9}};
        valid4 = 1'b1;
      end else begin
        valid4 = 1'b0;
      end
      check($sformatf("bp hold valid c%0d", c), {rdy4, ov4}, 2'b01);
      check($sformatf("bp hold o_c c%0d", c), c4, e4);
      tick();
    end
    valid4 = 1'b0;
    consume4("bp");

    // Reset at T+5 aborts the tile; a following accumulate tile shows no residue.
    acc4 = 1'b0;
    a4 = {16{8'd3}};
    b4 = {16{8'd3}};
    valid4 = 1'b1;
    tick();
    valid4 = 1'b0;
    repeat (4) tick();
    rst4 = 1'b1;
    #1;
    check("abort handshake in reset", {rdy4, ov4}, 2'b10);
    check("abort o_c in reset", c4, '0);
    tick();
    rst4 = 1'b0;
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      if (ov4 !== 1'b0 || rdy4 !== 1'b1) seen++;
      tick();
    end
    check("abort stays idle", seen, 0);
    acc4 = 1'b1;
    a4 = {16{8'd1}};
    for (int i = 0; i < N4; i++)
      for (int j = 0; j < N4; j++) b4[i][j] = DW4'(4 * i + j);
    run4("post abort");
    for (int i = 0; i < N4; i++)
      for (int j = 0; j < N4; j++) e4[i][j] = AW'(24 + 4 * j);
    check("post abort no residue", c4, e4);
    consume4("post abort");

    // N=3, DATA_W=4: all 15s, result at T+8 with i_ready held high.
    ready3 = 1'b1;
    a3 = {9{4'hF}};
    b3 = {9{4'hF}};
    valid3 = 1'b1;
    tick();
    valid3 = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      check($sformatf("n3 busy T+%0d", c), {rdy3, ov3}, 2'b00);
      tick();
    end
    check("n3 valid T+8", {rdy3, ov3}, 2'b01);
    check("n3 c==675", c3, {9{32'd675}});
    tick();

    // Back-to-back random tiles: one accept every 9 cycles.
    valid3 = 1'b1;
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < N3; i++)
        for (int j = 0; j < N3; j++) begin
          a3[i][j] = DW3'($urandom_range(0, 15));
          b3[i][j] = DW3'($urandom_range(0, 15));
        end
      sgn3 = 1'($urandom_range(0, 1));
      e3 = model3(a3, b3, sgn3);
      check($sformatf("b2b%0d ready", t), {rdy3, ov3}, 2'b10);
      tick();
      repeat (7) tick();
      check($sformatf("b2b%0d valid", t), {rdy3, ov3}, 2'b01);
      check($sformatf("b2b%0d c", t), c3, e3);
      tick();
    end
    valid3 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
